// File: rtl/sipo_frame_reg.sv
// Serial-in parallel-out frame register: assembles WIDTH-bit words from a qualified
// bit stream (MSB- or LSB-first) and emits full or zero-padded flushed words.
module sipo_frame_reg #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                         clk,
  input  logic                         clear_n,
  input  logic                         din,
  input  logic                         din_valid,
  input  logic                         flush,
  output logic [WIDTH-1:0]             dout,
  output logic                         dout_valid,
  output logic                         dout_partial,
  output logic [$clog2(WIDTH+1)-1:0]   dout_count,
  output logic [$clog2(WIDTH)-1:0]     bit_count,
  output logic                         busy
);

  localparam int CW  = $clog2(WIDTH);
  localparam int DCW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_C  = CW'(WIDTH - 1);
  localparam logic [DCW-1:0] WIDTH_C = DCW'(WIDTH);

  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_dout_partial;
  logic [DCW-1:0]   r_dout_count;

  logic [WIDTH-1:0] w_shift_next;
  logic [DCW-1:0]   w_k;
  logic [DCW-1:0]   w_shamt;
  logic             w_full;
  logic             w_flush_emit;
  logic [WIDTH-1:0] w_partial_word;

  always_comb begin
    w_shift_next = r_shift;
    if (din_valid) begin
      if (LSB_FIRST) w_shift_next = {din, r_shift[WIDTH-1:1]};
      else           w_shift_next = {r_shift[WIDTH-2:0], din};
    end
  end

  // k counts the bit accepted on this same edge, so a flush can carry it
  assign w_k          = DCW'(r_count) + DCW'(din_valid);
  assign w_full       = din_valid && (r_count == LAST_C);
  assign w_flush_emit = flush && !w_full && (w_k != '0);
  assign w_shamt      = WIDTH_C - w_k;

  always_comb begin
    if (LSB_FIRST) w_partial_word = w_shift_next >> w_shamt;
    else           w_partial_word = w_shift_next << w_shamt;
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_shift        <= '0;
      r_count        <= '0;
      r_dout         <= '0;
      r_dout_valid   <= 1'b0;
      r_dout_partial <= 1'b0;
      r_dout_count   <= '0;
    end else begin
      r_dout_valid <= 1'b0;
      if (w_full) begin
        r_dout         <= w_shift_next;
        r_dout_valid   <= 1'b1;
        r_dout_partial <= 1'b0;
        r_dout_count   <= WIDTH_C;
        r_shift        <= '0;
        r_count        <= '0;
      end else if (w_flush_emit) begin
        r_dout         <= w_partial_word;
        r_dout_valid   <= 1'b1;
        r_dout_partial <= 1'b1;
        r_dout_count   <= w_k;
        r_shift        <= '0;
        r_count        <= '0;
      end else if (din_valid) begin
        r_shift <= w_shift_next;
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign dout         = r_dout;
  assign dout_valid   = r_dout_valid;
  assign dout_partial = r_dout_partial;
  assign dout_count   = r_dout_count;
  assign bit_count    = r_count;
  assign busy         = (r_count != '0);

endmodule

// File: tb/tb_sipo_frame_reg.sv
// Bench for sipo_frame_reg: MSB-first and LSB-first instances share one stimulus
// stream; a bit-list model is compared every cycle, plus literal word checks.
module tb_sipo_frame_reg;
  localparam int W   = 8;
  localparam int CW  = $clog2(W);
  localparam int DCW = $clog2(W + 1);

  logic clk = 1'b0;
  logic clear_n = 1'b0, din = 1'b0, din_valid = 1'b0, flush = 1'b0;

  logic [W-1:0]   dout_m, dout_l;
  logic           v_m, v_l, p_m, p_l, busy_m, busy_l;
  logic [DCW-1:0] dc_m, dc_l;
  logic [CW-1:0]  bc_m, bc_l;

  always #5 clk = ~clk;

  sipo_frame_reg #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .clear_n(clear_n), .din(din), .din_valid(din_valid), .flush(flush),
    .dout(dout_m), .dout_valid(v_m), .dout_partial(p_m), .dout_count(dc_m),
    .bit_count(bc_m), .busy(busy_m));

  sipo_frame_reg #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .clear_n(clear_n), .din(din), .din_valid(din_valid), .flush(flush),
    .dout(dout_l), .dout_valid(v_l), .dout_partial(p_l), .dout_count(dc_l),
    .bit_count(bc_l), .busy(busy_l));

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: remembers the received bits in arrival order, builds words from them
  int m_bits[W];
  int m_k = 0;
  int e_msb = 0, e_lsb = 0, e_valid = 0, e_part = 0, e_cnt = 0;
  bit m_init = 1'b0;
  int cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (!clear_n) begin
      m_init = 1'b1;
      m_k = 0; e_msb = 0; e_lsb = 0; e_valid = 0; e_part = 0; e_cnt = 0;
    end else begin
      e_valid = 0;
      if (din_valid) begin
        m_bits[m_k] = int'(din);
        m_k++;
      end
      if (m_k == W || (flush && m_k > 0)) begin
        e_msb = 0;
        e_lsb = 0;
        for (int i = 0; i < m_k; i++) begin
          e_msb += m_bits[i] << (W - 1 - i);
          e_lsb += m_bits[i] << i;
        end
        e_valid = 1;
        e_part  = (m_k < W) ? 1 : 0;
        e_cnt   = m_k;
        m_k     = 0;
      end
    end
  end

  int q_m[$], q_mc[$], q_mp[$], q_mn[$], q_l[$], q_lp[$], q_ln[$];

  always @(negedge clk) begin
    if (m_init) begin
      chk("msb_dout",    int'(dout_m), e_msb);
      chk("msb_valid",   int'(v_m),    e_valid);
      chk("msb_partial", int'(p_m),    e_part);
      chk("msb_dcount",  int'(dc_m),   e_cnt);
      chk("msb_bitcnt",  int'(bc_m),   m_k);
      chk("msb_busy",    int'(busy_m), (m_k != 0) ? 1 : 0);
      chk("lsb_dout",    int'(dout_l), e_lsb);
      chk("lsb_valid",   int'(v_l),    e_valid);
      chk("lsb_partial", int'(p_l),    e_part);
      chk("lsb_dcount",  int'(dc_l),   e_cnt);
      chk("lsb_bitcnt",  int'(bc_l),   m_k);
      chk("lsb_busy",    int'(busy_l), (m_k != 0) ? 1 : 0);
    end
    if (v_m) begin
      q_m.push_back(int'(dout_m)); q_mc.push_back(cyc);
      q_mp.push_back(int'(p_m));   q_mn.push_back(int'(dc_m));
    end
    if (v_l) begin
      q_l.push_back(int'(dout_l)); q_lp.push_back(int'(p_l)); q_ln.push_back(int'(dc_l));
    end
  end

  function automatic int qat(int q[$], int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic qclear();
    q_m.delete(); q_mc.delete(); q_mp.delete(); q_mn.delete();
    q_l.delete(); q_lp.delete(); q_ln.delete();
  endtask

  task automatic step(input logic d, input logic v, input logic f, input logic c);
    din = d; din_valid = v; flush = f; clear_n = c;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send_byte(input logic [W-1:0] b);
    for (int i = W - 1; i >= 0; i--) step(b[i], 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    logic [W-1:0] pat;
    int gaps[W];
    gaps = '{0, 1, 2, 3, 0, 2, 1, 3};

    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    idle(4);
    chk("rst_dout", int'(dout_m), 0);
    chk("rst_bitcnt", int'(bc_m), 0);
    chk("rst_pulses", q_m.size() + q_l.size(), 0);

    // MSB-first word B2 (LSB-first instance sees 4D)
    qclear();
    send_byte(8'hB2);
    chk("w1_bitcnt_after", int'(bc_m), 0);
    idle(3);
    chk("w1_npulse", q_m.size(), 1);
    chk("w1_msb_word", qat(q_m, 0), 'hB2);
    chk("w1_partial", qat(q_mp, 0), 0);
    chk("w1_count", qat(q_mn, 0), 8);
    chk("w1_lsb_word", qat(q_l, 0), 'h4D);

    // Same bits with idle gaps
    qclear();
    pat = 8'hB2;
    for (int i = 0; i < W; i++) begin
      step(pat[W-1-i], 1'b1, 1'b0, 1'b1);
      idle(gaps[i]);
      if (i < W - 1 && gaps[i] > 0) chk("gap_bitcnt_hold", int'(bc_l), i + 1);
    end
    idle(2);
    chk("gap_npulse", q_l.size(), 1);
    chk("gap_lsb_word", qat(q_l, 0), 'h4D);
    chk("gap_msb_word", qat(q_m, 0), 'hB2);

    // Back-to-back words
    qclear();
    send_byte(8'hB2);
    send_byte(8'h5A);
    idle(2);
    chk("b2b_npulse", q_m.size(), 2);
    chk("b2b_word0", qat(q_m, 0), 'hB2);
    chk("b2b_word1", qat(q_m, 1), 'h5A);
    chk("b2b_spacing", qat(q_mc, 1) - qat(q_mc, 0), 8);

    // Flush after three bits
    qclear();
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);
    chk("fl_npulse", q_m.size(), 1);
    chk("fl_msb_word", qat(q_m, 0), 'hA0);
    chk("fl_lsb_word", qat(q_l, 0), 'h05);
    chk("fl_partial", qat(q_mp, 0), 1);
    chk("fl_count", qat(q_mn, 0), 3);
    chk("fl_lsb_count", qat(q_ln, 0), 3);

    // Flush with nothing accumulated
    qclear();
    step(1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);
    chk("fl_empty_npulse", q_m.size() + q_l.size(), 0);
    chk("fl_empty_hold", int'(dout_m), 'hA0);

    // Flush on the same edge as the third bit
    qclear();
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    idle(2);
    chk("fl_same_msb", qat(q_m, 0), 'hA0);
    chk("fl_same_lsb", qat(q_l, 0), 'h05);
    chk("fl_same_count", qat(q_mn, 0), 3);

    // Flush coinciding with the eighth bit gives a full word
    qclear();
    pat = 8'hC3;
    for (int i = 0; i < W; i++) step(pat[W-1-i], 1'b1, (i == W - 1) ? 1'b1 : 1'b0, 1'b1);
    idle(2);
    chk("fl_full_npulse", q_m.size(), 1);
    chk("fl_full_word", qat(q_m, 0), 'hC3);
    chk("fl_full_partial", qat(q_mp, 0), 0);
    chk("fl_full_count", qat(q_mn, 0), 8);
    chk("fl_full_lsb_partial", qat(q_lp, 0), 0);

    // Reset mid-frame
    qclear();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    send_byte(8'hC3);
    idle(2);
    chk("rmf_npulse", q_m.size(), 1);
    chk("rmf_word", qat(q_m, 0), 'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sipo_frame_reg.md
# sipo_frame_reg

Parametrised serial-in parallel-out frame register, the successor to the fixed 4-bit SIPO. It accepts a qualified serial bit stream, assembles WIDTH-bit words MSB-first or LSB-first, and presents each completed word on a registered parallel output with a one-cycle valid strobe. A flush input emits a zero-padded partial word. It sits between serial receive logic and any word-wide consumer.

## Interface

- `WIDTH`, default 8: word length in bits; must be at least 2.
- `LSB_FIRST`, default 0: bit order. 0 means the first received bit lands in `dout[WIDTH-1]`; 1 means the first received bit lands in `dout[0]`.
- `clk` input, 1 bit: the only clock; all state updates on its rising edge.
- `clear_n` input, 1 bit: reset, synchronous and active-low. 0 at a rising edge clears all state.
- `din` input, 1 bit: serial data, sampled only when `din_valid` is 1.
- `din_valid` input, 1 bit: qualifies `din`. One bit is accepted per edge where it is 1.
- `flush` input, 1 bit: requests emission of the bits accumulated so far.
- `dout` output, WIDTH bits: last emitted word. Registered and held until the next emission.
- `dout_valid` output, 1 bit: one-cycle pulse marking a new `dout`.
- `dout_partial` output, 1 bit: 1 when the word now on `dout` came from a flush with fewer than WIDTH bits.
- `dout_count` output, $clog2(WIDTH+1) bits: number of real bits in `dout` (WIDTH for a full word).
- `bit_count` output, $clog2(WIDTH) bits: bits currently accumulated, range 0..WIDTH-1.
- `busy` output, 1 bit: 1 when `bit_count` is non-zero.

## Operation

- **Reset.** `clear_n`=0 at an edge:
  - `shift_q`, `bit_count`, `dout`, `dout_valid`, `dout_partial`, `dout_count` and `busy` all become 0.
  - Reset overrides all other inputs, including a reset in the middle of a frame; the partial bits are discarded and nothing is emitted.
- **Accept.** On an edge with `din_valid`=1:
  - With LSB_FIRST=0, `shift_q` <= {`shift_q[WIDTH-2:0]`, `din`}.
  - With LSB_FIRST=1, `shift_q` <= {`din`, `shift_q[WIDTH-1:1]`}.
  - `bit_count` increments.
- **Idle.** With `din_valid`=0, `shift_q` and `bit_count` hold.
- **Full word.** An accept with `bit_count`=WIDTH-1 completes a word:
  - `dout` <= the post-shift value, `dout_valid` <= 1, `dout_partial` <= 0, `dout_count` <= WIDTH.
  - `bit_count` and `shift_q` return to 0 (wrap-around).
- **Flush.** On an edge with `flush`=1, let k be the bit count including any bit accepted on that same edge.
  - If 1 <= k <= WIDTH-1:
    - With LSB_FIRST=0, `dout` <= `shift_q` << (WIDTH-k), so the first bit is at the MSB and the low bits are 0.
    - With LSB_FIRST=1, `dout` <= `shift_q` >> (WIDTH-k), so the first bit is at bit 0 and the high bits are 0.
    - `dout_valid` <= 1, `dout_partial` <= 1, `dout_count` <= k; `bit_count` and `shift_q` clear.
  - If k=0: no emission and no state change.
  - If the same edge completes a full word: only the normal full-word emission occurs, with `dout_partial`=0.
- **Outputs between emissions.**
  - `dout_valid` is 0 on every edge without an emission.
  - `dout`, `dout_partial` and `dout_count` hold between emissions.
  - There is no backpressure. The consumer must take the word in the pulse cycle; the next emission overwrites it.

## Timing

- Latency: a bit sampled at edge N that completes a word (or a flush at edge N) produces `dout`/`dout_valid` updated at edge N, visible during the following cycle.
- Continuous `din_valid` gives one `dout_valid` pulse every WIDTH cycles, with no dead cycle between words.
- `bit_count` and `busy` reflect accepted bits from the edge after acceptance.
- All outputs are registered; there is no combinational path from input to output.

## Test plan

- **Reset.** Drive `clear_n`=0 for 2 edges with random `din`/`din_valid`/`flush` -> all outputs 0. After release with inputs idle, outputs stay 0.
- **MSB-first word.** WIDTH=8, LSB_FIRST=0, bits 1,0,1,1,0,0,1,0 on consecutive edges -> `dout`=8'hB2, `dout_valid` high for exactly 1 cycle, `dout_partial`=0, `dout_count`=8, `bit_count`=0.
- **LSB-first and gaps.** LSB_FIRST=1, same bits with 0-3 idle cycles between them -> `dout`=8'h4D; `bit_count` holds during the idle cycles.
- **Back-to-back.** 16 continuous bits forming 8'hB2 then 8'h5A (MSB-first) -> two `dout_valid` pulses exactly 8 cycles apart, carrying the values in that order.
- **Flush.** Three bits 1,0,1 then `flush` -> MSB-first `dout`=8'hA0, LSB-first `dout`=8'h05, with `dout_partial`=1 and `dout_count`=3. A flush when `bit_count`=0 produces no pulse. A flush on the edge of the 8th bit produces a full word with `dout_partial`=0.
- **Reset mid-frame.** 5 bits, then `clear_n`=0 for 1 edge, then 8 bits forming 8'hC3 -> exactly one pulse, with `dout`=8'hC3.
